// File: rtl/adder_share_ctrl_pkg.sv
// Shared constants and pipeline bundle types for the shared prefix-adder controller.
package adder_share_ctrl_pkg;

    // Datapath width taken from the main define set; must stay a multiple of 8.
    localparam int LEN_DATA = 32;

    // Width of the opaque tag each requester attaches to its operation.
    localparam int TAG_W = 4;

    // Owner encodings, one per requester port.
    localparam logic OWNER_ALU = 1'b0;
    localparam logic OWNER_AGU = 1'b1;

    // Operand register contents: b is already conditioned for subtract.
    typedef struct packed {
        logic                owner;
        logic [TAG_W-1:0]    tag;
        logic                cin;
        logic [LEN_DATA-1:0] b;
        logic [LEN_DATA-1:0] a;
    } op_bundle_t;

    // Result register contents, packed as {owner, tag, ovf, cout, sum}.
    typedef struct packed {
        logic                owner;
        logic [TAG_W-1:0]    tag;
        logic                ovf;
        logic                cout;
        logic [LEN_DATA-1:0] sum;
    } res_bundle_t;

endpackage

// File: rtl/adder_prefix_core.sv
// Combinational Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module adder_prefix_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] gen_l  [LEVELS+1];
    logic [WIDTH-1:0] prop_l [LEVELS+1];
    logic [WIDTH:0]   carry;

    assign gen_l[0]  = a & b;
    assign prop_l[0] = a ^ b;

    // Each level merges group generate/propagate with the group 2^l bits below.
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int DIST = 1 << l;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_merge
                assign gen_l[l+1][i]  = gen_l[l][i] | (prop_l[l][i] & gen_l[l][i-DIST]);
                assign prop_l[l+1][i] = prop_l[l][i] & prop_l[l][i-DIST];
            end else begin : g_pass
                assign gen_l[l+1][i]  = gen_l[l][i];
                assign prop_l[l+1][i] = prop_l[l][i];
            end
        end
    end

    // Group terms span bit 0 upward, so folding in cin gives every bit's carry.
    assign carry = {gen_l[LEVELS] | (prop_l[LEVELS] & {WIDTH{cin}}), cin};
    assign sum   = prop_l[0] ^ carry[WIDTH-1:0];
    assign cout  = carry[WIDTH];

endmodule

// File: rtl/adder_rr_arb2.sv
// Two-input round-robin arbiter; grant bits do not depend on the same port's request.
module adder_rr_arb2
    import adder_share_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    // A port is eligible when the other port is idle or the pointer favours it.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = !req[1] || (ptr == OWNER_ALU);
        gnt[1] = !req[0] || (ptr == OWNER_AGU);
    end

    // After a transfer the pointer moves to the port that lost; refusals leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWNER_ALU;
        end else if (advance) begin
            ptr <= (req[0] && gnt[0]) ? OWNER_AGU : OWNER_ALU;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one prefix adder between the ALU and AGU ports through a 2-stage pipeline.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [LEN_DATA-1:0] req0_a,
    input  logic [LEN_DATA-1:0] req0_b,
    input  logic                req0_cin,
    input  logic                req0_sub,
    input  logic [TAG_W-1:0]    req0_tag,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [LEN_DATA-1:0] req1_a,
    input  logic [LEN_DATA-1:0] req1_b,
    input  logic                req1_cin,
    input  logic                req1_sub,
    input  logic [TAG_W-1:0]    req1_tag,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [LEN_DATA-1:0] res_sum,
    output logic                res_cout,
    output logic                res_ovf,
    output logic                res_owner,
    output logic [TAG_W-1:0]    res_tag,
    output logic                busy
);

    localparam int MSB = LEN_DATA - 1;

    logic                s1_valid;
    logic                s2_valid;
    op_bundle_t          s1_q;
    op_bundle_t          s1_d;
    res_bundle_t         s2_q;
    res_bundle_t         s2_d;
    logic [1:0]          arb_gnt;
    logic                s2_advance;
    logic                s1_can_load;
    logic                accept0;
    logic                accept1;
    logic                accept_any;
    logic [LEN_DATA-1:0] core_sum;
    logic                core_cout;

    assign s2_advance  = !s2_valid || res_ready;
    assign s1_can_load = !rst && (!s1_valid || s2_advance);
    assign req0_ready  = s1_can_load && arb_gnt[0];
    assign req1_ready  = s1_can_load && arb_gnt[1];
    assign accept0     = req0_valid && req0_ready;
    assign accept1     = req1_valid && req1_ready;
    assign accept_any  = accept0 || accept1;

    adder_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (accept_any),
        .gnt     (arb_gnt)
    );

    // Select the granted port and fold subtract into inverted b with carry-in forced to 1.
    always_comb begin
        s1_d = '0;
        if (accept1) begin
            s1_d.a     = req1_a;
            s1_d.b     = req1_sub ? ~req1_b : req1_b;
            s1_d.cin   = req1_sub | req1_cin;
            s1_d.owner = OWNER_AGU;
            s1_d.tag   = req1_tag;
        end else begin
            s1_d.a     = req0_a;
            s1_d.b     = req0_sub ? ~req0_b : req0_b;
            s1_d.cin   = req0_sub | req0_cin;
            s1_d.owner = OWNER_ALU;
            s1_d.tag   = req0_tag;
        end
    end

    // Operand register: refills whenever it is empty or its contents move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_can_load) begin
            s1_valid <= accept_any;
            if (accept_any) begin
                s1_q <= s1_d;
            end
        end
    end

    adder_prefix_core #(
        .WIDTH (LEN_DATA)
    ) u_core (
        .a    (s1_q.a),
        .b    (s1_q.b),
        .cin  (s1_q.cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Build the result bundle; overflow compares signs of the operands actually added.
    always_comb begin
        s2_d       = '0;
        s2_d.sum   = core_sum;
        s2_d.cout  = core_cout;
        s2_d.ovf   = (s1_q.a[MSB] == s1_q.b[MSB]) && (core_sum[MSB] != s1_q.a[MSB]);
        s2_d.owner = s1_q.owner;
        s2_d.tag   = s1_q.tag;
    end

    // Result register: holds steady under backpressure, otherwise takes the S1 result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign res_valid = s2_valid;
    assign res_sum   = s2_q.sum;
    assign res_cout  = s2_q.cout;
    assign res_ovf   = s2_q.ovf;
    assign res_owner = s2_q.owner;
    assign res_tag   = s2_q.tag;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed vectors, arbitration/backpressure/reset sequences, random traffic.
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_sum;
    logic        res_cout, res_ovf, res_owner;
    logic [3:0]  res_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        owner;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    exp_t  exp_q[$];
    int    acc_log[$];
    int    res_count = 0;
    int    model_ptr = 0;
    logic  prev_hold = 1'b0;
    logic [40:0] prev_res = '0;
    vec_t  vecs[6];

    adder_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_sub   (req0_sub),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_sub   (req1_sub),
        .req1_tag   (req1_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf),
        .res_owner  (res_owner),
        .res_tag    (res_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the outcome.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Arithmetic reference: add or subtract as integers, then derive carry and signed overflow.
    function automatic exp_t modelAdd(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                      input logic sub, input logic owner, input logic [3:0] tag);
        exp_t e;
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sres;
        longint unsigned wide;
        if (sub) begin
            wide   = ua - ub;
            e.cout = (ua >= ub);
            sres   = sa - sb;
        end else begin
            wide   = ua + ub + longint'(cin);
            e.cout = wide[32];
            sres   = sa + sb + longint'(cin);
        end
        e.sum   = wide[31:0];
        e.ovf   = (sres != longint'($signed(sres[31:0])));
        e.owner = owner;
        e.tag   = tag;
        return e;
    endfunction

    // Drive one port's request fields.
    task automatic setReq(input logic port, input logic valid, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [3:0] tag);
        if (port) begin
            req1_valid = valid; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_tag = tag;
        end else begin
            req0_valid = valid; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_tag = tag;
        end
    endtask

    // Scoreboard: track accepts, compare results in order, check grant fairness, busy and holds.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            checkOutput("ready_in_reset", {62'b0, req1_ready, req0_ready}, 64'd0);
            exp_q.delete();
            model_ptr = 0;
            prev_hold = 1'b0;
        end else begin
            checkOutput("busy", busy, exp_q.size() != 0);
            if (prev_hold) begin
                checkOutput("hold_stable", {res_owner, res_tag, res_ovf, res_cout, res_sum}, prev_res);
            end
            if (req0_valid && req1_valid && (req0_ready || req1_ready)) begin
                checkOutput("rr_grant", {req1_ready, req0_ready}, (model_ptr != 0) ? 64'd2 : 64'd1);
            end
            if (res_valid && res_ready) begin
                checkOutput("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("res_sum", res_sum, e.sum);
                    checkOutput("res_cout", res_cout, e.cout);
                    checkOutput("res_ovf", res_ovf, e.ovf);
                    checkOutput("res_owner", res_owner, e.owner);
                    checkOutput("res_tag", res_tag, e.tag);
                end
                res_count++;
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back(modelAdd(req0_a, req0_b, req0_cin, req0_sub, 1'b0, req0_tag));
                acc_log.push_back(0);
                model_ptr = 1;
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back(modelAdd(req1_a, req1_b, req1_cin, req1_sub, 1'b1, req1_tag));
                acc_log.push_back(1);
                model_ptr = 0;
            end
            checkOutput("in_flight_max2", exp_q.size() <= 2, 1);
            prev_hold = res_valid && !res_ready;
            prev_res  = {res_owner, res_tag, res_ovf, res_cout, res_sum};
        end
    end

    // Issue one vector alone, checking two-edge latency and the returned fields.
    task automatic applyStimulus(input vec_t v);
        int  n = 0;
        logic got = 1'b0;
        @(negedge clk);
        res_ready = 1'b1;
        setReq(v.port, 1'b1, v.a, v.b, v.cin, v.sub, v.tag);
        while (!got && n < 20) begin
            #1;
            got = v.port ? req1_ready : req0_ready;
            if (!got) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("accept_timeout", got, 1);
        @(negedge clk);
        setReq(v.port, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("latency_early", res_valid, 0);
        @(negedge clk);
        checkOutput("latency_valid", res_valid, 1);
        checkOutput("vec_sum", res_sum, v.exp_sum);
        checkOutput("vec_cout", res_cout, v.exp_cout);
        checkOutput("vec_ovf", res_ovf, v.exp_ovf);
        checkOutput("vec_owner", res_owner, v.port);
        checkOutput("vec_tag", res_tag, v.tag);
    endtask

    // Wait for all in-flight work to return, bounded.
    task automatic waitDrain();
        int n = 0;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput("drain", {exp_q.size() != 0, busy}, 0);
    endtask

    // Synchronous reset for one edge.
    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Both ports valid briefly: the port-0 side must be the one offered the slot.
    task automatic checkPtrZero(input string name);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput(name, {req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h5, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'hA, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'hC, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 4'hF, 32'h0000_0007, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_res_bundle", {res_owner, res_tag, res_ovf, res_cout, res_sum}, 0);
        checkPtrZero("reset_ptr");

        // Directed vectors one at a time.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end
        waitDrain();

        // Both ports valid for four cycles: grants alternate starting at port 0.
        pulseReset();
        acc_log.delete();
        @(negedge clk);
        res_ready = 1'b1;
        setReq(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0011, 1'b0, 1'b0, 4'h2);
        setReq(1'b1, 1'b1, 32'h0000_2000, 32'h0000_0022, 1'b1, 1'b0, 4'h9);
        repeat (4) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        checkOutput("alt_count", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            checkOutput("alt_order", {acc_log[0][0], acc_log[1][0], acc_log[2][0], acc_log[3][0]}, 64'b0101);
        end
        checkPtrZero("alt_ptr_back_to_0");
        waitDrain();

        // Backpressure: five stalled cycles with port 0 streaming.
        pulseReset();
        acc_log.delete();
        res_count = 0;
        @(negedge clk);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setReq(1'b0, 1'b1, 32'h0000_0100 + i, 32'h0000_0010, 1'b0, 1'b0, 4'(i));
            @(negedge clk);
        end
        #1;
        checkOutput("bp_accepts", acc_log.size(), 2);
        checkOutput("bp_ready_low", req0_ready, 0);
        checkOutput("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            setReq(1'b0, 1'b1, 32'h0000_0200 + i, 32'h0000_0020, 1'b0, 1'b0, 4'(8 + i));
            @(negedge clk);
        end
        req0_valid = 1'b0;
        #3;
        checkOutput("bp_total_accepts", acc_log.size(), 6);
        waitDrain();
        checkOutput("bp_results", res_count, 6);

        // Reset while both stages hold work.
        @(negedge clk);
        res_ready = 1'b0;
        setReq(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'h7);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("full_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_ready0", req0_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        #1;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkPtrZero("rst_ptr");
        applyStimulus(vecs[0]);
        waitDrain();

        // Random traffic with occasional resets and backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 249) == 0);
            res_ready = ($urandom_range(0, 9) < 7);
            setReq(1'b0, $urandom_range(0, 9) < 6,
                   ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                   ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            setReq(1'b1, $urandom_range(0, 9) < 6,
                   ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom,
                   ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one parallel-prefix adder core between two requesters: port 0 is the ALU issue path, port 1 is the address-generation / branch-target path.
- Round-robin arbitration, a 2-stage registered pipeline (operand register, then result register) and valid/ready backpressure.
- Sits between the issue logic and the existing prefix adder. The core is instantiated unmodified and is purely combinational between the two register stages.

Parameters:
- LEN_DATA, 32, operand/result width; taken from the main define file; multiple of 8.
- TAG_W, 4, requester-supplied tag width, returned with the result.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid / req1_valid  in  1  request from port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  LEN_DATA  operands.
- req0_cin / req1_cin  in  1  carry-in.
- req0_sub / req1_sub  in  1  subtract: core computes a + ~b + 1 and ignores cin.
- req0_tag / req1_tag  in  TAG_W  opaque tag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  LEN_DATA  sum.
- res_cout  out  1  carry-out.
- res_ovf  out  1  signed overflow.
- res_owner  out  1  0 = port 0, 1 = port 1.
- res_tag  out  TAG_W  tag of the owning request.
- busy  out  1  either pipeline stage occupied.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset state:
  - s1_valid = 0, s2_valid = 0, res_valid = 0, busy = 0.
  - Round-robin pointer = 0 (port 0 has priority first).
  - res_sum, res_cout, res_ovf, res_owner and res_tag = 0.
- Stage rules:
  - S2 (result register) advances when !s2_valid or res_ready.
  - S1 (operand register) can load when !s1_valid or S1 advances into S2.
  - reqN_ready is combinational: S1 can load AND the arbiter grants N. It never depends on reqN_valid of the same port.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: grant the port equal to the pointer.
  - After each accepted transfer, the pointer = ~granted port.
  - A port that is valid but refused holds the pointer unchanged, so there is no starvation.
- Operand capture: S1 stores a, b (b inverted when sub), carry-in (1 when sub), owner and tag.
- Compute: the adder core evaluates S1 combinationally. S2 captures:
  - sum;
  - cout = carry out of bit LEN_DATA-1;
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  - owner and tag.
- Latency:
  - Accept at edge k; res_valid high after edge k+1.
  - Throughput 1 result/cycle while res_ready = 1.
- Backpressure:
  - With res_ready = 0 and S2 full, S2 and res_* hold stable.
  - S1 may fill once; then both reqN_ready = 0.
  - No result is dropped or duplicated.
- Simultaneous events: in the cycle res_ready drains S2, S1 moves into S2 and a new request loads S1 in the same edge.
- Reset mid-operation:
  - Both stages are invalidated on the next edge and in-flight results are discarded.
  - reqN_ready = 0 while rst = 1.
- busy = s1_valid | s2_valid.
- Width wrap: sums are modulo 2^LEN_DATA, with the carry reported in res_cout only.

Decomposition:
- Shared package / define file holds:
  - LEN_DATA (existing);
  - TAG_W;
  - OWNER_ALU = 1'b0 and OWNER_AGU = 1'b1 constants;
  - a result-bundle packing order {owner, tag, ovf, cout, sum} for the pipeline registers.
- One natural sub-module, adder_rr_arb2: 2-input round-robin arbiter with pointer register, grant vector and an advance input.
- The prefix adder core is instantiated as-is.

Test Plan:
- Single ALU add: req0 a=32'h0000_00FF, b=32'h0000_0001, cin=0, tag=3 -> res_valid one cycle after the accept edge, sum=32'h0000_0100, cout=0, ovf=0, owner=0, tag=3.
- Subtract with overflow: req1 sub=1, a=32'h8000_0000, b=1 -> sum=32'h7FFF_FFFF, cout=1, ovf=1, owner=1.
- Both valid for 4 cycles, res_ready=1:
  - grants alternate 0,1,0,1 and results emerge in the same order;
  - then the pointer is 0 again.
- Backpressure: res_ready=0 for 5 cycles with req0 continuously valid:
  - exactly 2 accepts, then req0_ready=0;
  - res_* stable throughout;
  - after release, 2 results then new accepts, with no loss or duplication.
- Carry wrap: a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Reset with both stages full: assert rst for 1 cycle -> next cycle res_valid=0, busy=0, pointer=0, and the next request completes normally.
